// File: rtl/mul_unit_pkg.sv
// Shared widths, op/state encodings and operand helpers for the iterative
// radix-4 Booth multiplier.
package mul_unit_pkg;

    localparam int WORD   = 32;
    localparam int EXT_W  = WORD + 2;
    localparam int DIGITS = EXT_W / 2;
    localparam int PP_W   = EXT_W + 1;
    localparam int ACC_W  = 2 * EXT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        MUL_W   = 2'b00,
        MULH_W  = 2'b01,
        MULH_WU = 2'b10,
        MUL_RSV = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        MU_IDLE = 2'b00,
        MU_BUSY = 2'b01,
        MU_DONE = 2'b10
    } mu_state_e;

    // Two extra bits let both signed and unsigned 32-bit operands be held as
    // 34-bit two's complement, so one Booth datapath serves all three ops.
    function automatic logic [EXT_W-1:0] extend_operand(input logic [WORD-1:0] v,
                                                        input logic            is_signed);
        return {{(EXT_W - WORD){is_signed & v[WORD-1]}}, v};
    endfunction

    function automatic logic [WORD-1:0] select_half(input mul_op_e           op,
                                                    input logic [2*WORD-1:0] prod);
        return (op == MULH_W || op == MULH_WU) ? prod[2*WORD-1:WORD] : prod[WORD-1:0];
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product selector: maps a multiplier triplet onto
// {0, +A, +2A, -2A, -A} of the 34-bit multiplicand.
module booth_r4_pp
    import mul_unit_pkg::*;
(
    input  logic [EXT_W-1:0] mcand_i,
    input  logic [2:0]       triplet_i,
    output logic [PP_W-1:0]  pp_o
);

    logic [PP_W-1:0] a_one;
    logic [PP_W-1:0] a_two;

    assign a_one = {mcand_i[EXT_W-1], mcand_i};
    assign a_two = {mcand_i, 1'b0};

    always_comb begin
        pp_o = '0;
        case (triplet_i)
            3'b001, 3'b010: pp_o = a_one;
            3'b011:         pp_o = a_two;
            3'b100:         pp_o = -a_two;
            3'b101, 3'b110: pp_o = -a_one;
            default:        pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-4 Booth multiplier for mul.w / mulh.w / mulh.wu with
// valid/ready handshakes on both sides and a synchronous flush.
module mul_unit
    import mul_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      MUL_op,
    input  logic [WORD-1:0] src_a,
    input  logic [WORD-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] MUL_res
);

    mu_state_e        state_q,     state_d;
    mul_op_e          op_q,        op_d;
    logic [EXT_W-1:0] mcand_q,     mcand_d;
    logic [EXT_W:0]   mplier_q,    mplier_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [WORD-1:0]  res_q,       res_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             last_digit;
    mul_op_e          op_in;
    logic             op_in_signed;
    logic [PP_W-1:0]  pp;
    logic [ACC_W-1:0] pp_weighted;
    logic [ACC_W-1:0] acc_sum;

    assign in_ready   = (state_q == MU_IDLE) | ((state_q == MU_DONE) & out_ready);
    assign accept     = in_valid & in_ready & ~flush;
    assign last_digit = (count_q == CNT_W'(DIGITS - 1));
    assign out_valid  = out_valid_q;
    assign MUL_res    = res_q;

    assign op_in        = (mul_op_e'(MUL_op) == MUL_RSV) ? MUL_W : mul_op_e'(MUL_op);
    assign op_in_signed = (op_in != MULH_WU);

    // The multiplier register carries b[-1]=0 in bit 0, so the low three bits
    // are always the current Booth triplet as it shifts right two per digit.
    booth_r4_pp u_pp (
        .mcand_i   (mcand_q),
        .triplet_i (mplier_q[2:0]),
        .pp_o      (pp)
    );

    assign pp_weighted = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp} << {count_q, 1'b0};
    assign acc_sum     = acc_q + pp_weighted;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = MU_IDLE;
            out_valid_d = 1'b0;
            count_d     = '0;
        end else begin
            case (state_q)
                MU_BUSY: begin
                    acc_d    = acc_sum;
                    mplier_d = {{2{mplier_q[EXT_W]}}, mplier_q[EXT_W:2]};
                    count_d  = count_q + CNT_W'(1);
                    if (last_digit) begin
                        state_d     = MU_DONE;
                        out_valid_d = 1'b1;
                        res_d       = select_half(op_q, acc_sum[2*WORD-1:0]);
                    end
                end
                MU_DONE: begin
                    if (out_ready && !in_valid) begin
                        state_d     = MU_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                MU_IDLE: state_d = MU_IDLE;
                default: state_d = MU_IDLE;
            endcase

            // Covers both a fresh start from IDLE and a back-to-back start from DONE.
            if (accept) begin
                state_d     = MU_BUSY;
                op_d        = op_in;
                mcand_d     = extend_operand(src_a, op_in_signed);
                mplier_d    = {extend_operand(src_b, op_in_signed), 1'b0};
                acc_d       = '0;
                count_d     = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MU_IDLE;
            op_q        <= MUL_W;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  MUL_op = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] MUL_res;

    int tests = 0;
    int fails = 0;

    mul_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .MUL_op    (MUL_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MUL_res   (MUL_res)
    );

    always #5 clk = ~clk;

    // Reference product straight from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        case (op)
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return up[31:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: an op in flight with a countdown, and a held result.
    bit          m_busy  = 1'b0;
    int          m_left  = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_res   = 32'd0;
    logic [31:0] m_pend  = 32'd0;

    initial begin
        bit take;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_busy = 1'b0; m_left = 0; m_valid = 1'b0; m_res = 32'd0;
            end else if (flush) begin
                m_busy = 1'b0; m_valid = 1'b0;
            end else begin
                take = in_valid && !m_busy && (!m_valid || out_ready);
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_valid = 1'b1; m_res = m_pend;
                    end
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
                if (take) begin
                    m_busy = 1'b1; m_left = 17; m_pend = ref_mul(MUL_op, src_a, src_b);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chkb("cyc_rst_out_valid", out_valid, 1'b0);
                chk("cyc_rst_MUL_res", MUL_res, 32'd0);
            end else begin
                chkb("cyc_in_ready", in_ready, !m_busy && (!m_valid || out_ready));
                chkb("cyc_out_valid", out_valid, m_valid);
                chk("cyc_MUL_res", MUL_res, m_res);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; MUL_op = op; src_a = a; src_b = b;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        chkb("accept_in_time", ok, 1'b1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        out_ready = 1'b1;
        issue(op, a, b);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'd17);
        chk({name, "_res"}, MUL_res, exp);
        $display("[TB] %s op=%0d a=%h b=%h res=%h lat=%0d", name, op, a, b, MUL_res, lat);
        step();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] held;
        bit          seen;
        bit          holding;
        bit          go;
        int          accepted;
        int          cyc;

        // Pin the reference model to hand-computed products.
        chk("model_mulw_7xm3", ref_mul(2'b00, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_mulhw_min", ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model_mulhwu_max", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

        #1;
        chkb("reset_out_valid", out_valid, 1'b0);
        chk("reset_MUL_res", MUL_res, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chkb("reset_in_ready", in_ready, 1'b1);

        run_op("mulw_7_m3",      2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhw_min_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulw_min_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("mulhwu_min_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhwu_m1_m1",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhw_m1_m1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulw_m1_m1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("reserved_op",    2'b11, 32'd12345,     32'd1000,      32'd12345000);

        // Backpressure in DONE, then a back-to-back accept on the release edge.
        out_ready = 1'b0;
        issue(2'b01, 32'hFFFF_FFFF, 32'd5);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd17);
        chk("bp_res", MUL_res, 32'hFFFF_FFFF);
        held = MUL_res;
        for (int i = 0; i < 5; i++) begin
            step();
            chkb("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_res", MUL_res, held);
            chkb("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1; in_valid = 1'b1; MUL_op = 2'b10;
        src_a = 32'h0001_0000; src_b = 32'h0001_0000;
        #1 chkb("b2b_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chkb("b2b_valid_dropped", out_valid, 1'b0);
        wait_valid(lat);
        chk("b2b_latency", 32'(lat), 32'd17);
        chk("b2b_res", MUL_res, 32'h0000_0001);
        $display("[TB] back_to_back res=%h lat=%0d", MUL_res, lat);
        step();

        // Flush at count==8, then flush colliding with in_valid in IDLE.
        issue(2'b00, 32'd3, 32'd4);
        repeat (8) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chkb("flush_idle_in_ready", in_ready, 1'b1);
        chkb("flush_out_valid", out_valid, 1'b0);
        flush = 1'b1; in_valid = 1'b1; MUL_op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        step();
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chkb("flush_no_result", seen, 1'b0);
        $display("[TB] flush_mid_op result_seen=%0d", seen);

        // Asynchronous reset mid-op clears outputs before any clock edge.
        issue(2'b00, 32'd7, 32'd9);
        repeat (5) step();
        rst = 1'b0;
        #1;
        chkb("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_MUL_res", MUL_res, 32'd0);
        $display("[TB] async_reset_mid_op out_valid=%0d res=%h", out_valid, MUL_res);
        repeat (2) step();
        rst = 1'b1;
        step();

        // Randomized traffic; the per-cycle compare process does the checking.
        holding = 1'b0; accepted = 0; cyc = 0;
        while (accepted < 2000 && cyc < 80000) begin
            if (!holding && $urandom_range(0, 3) != 0) begin
                holding = 1'b1;
                MUL_op  = 2'($urandom_range(0, 3));
                src_a   = rnd_operand();
                src_b   = rnd_operand();
            end
            in_valid  = holding;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) < 2);
            #1;
            go = holding && in_ready && !flush;
            step();
            if (go) begin
                holding = 1'b0;
                accepted++;
            end
            cyc++;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        chkb("random_budget", accepted >= 2000, 1'b1);
        $display("[TB] random ops accepted=%0d cycles=%0d", accepted, cyc);
        repeat (25) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
